// File: rtl/data_ram_burst.sv
// Burst RAM with fixed access latency and critical-word-first wrapping bursts.
// Optional byte-lane write strobes when DATA_RAM_WSTRB_EN is defined.
module data_ram_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CLK_DELAY  = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    we,
    input  logic [31:0]             addr,
    input  logic [DATA_WIDTH-1:0]   din,
`ifdef DATA_RAM_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] wstrb,
`endif
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    ack,
    output logic                    last,
    output logic                    stall
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LMASK = ADDR_WIDTH'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) m[i] = DATA_WIDTH'(i);
        return m;
    endfunction

    // Contents survive reset; only the power-up image is index-valued.
    mem_t mem = mem_init();

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   abuf_q, abuf_d;
    logic                    wbuf_q, wbuf_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    ack_q, ack_d;
    logic                    last_q, last_d;

    logic                    do_beat;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   cur_beat;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_WIDTH];

    // Line base from the buffered address, offset wraps inside the line.
    assign idx = (abuf_q & ~LMASK) | ((abuf_q + cur_beat) & LMASK);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        abuf_d   = abuf_q;
        wbuf_d   = wbuf_q;
        dout_d   = '0;
        ack_d    = 1'b0;
        last_d   = 1'b0;
        do_beat  = 1'b0;
        cur_beat = beat_q;

        if (!cs) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    abuf_d  = addr[ADDR_WIDTH-1:0];
                    wbuf_d  = we;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (addr[ADDR_WIDTH-1:0] != abuf_q || we != wbuf_q) begin
                        abuf_d = addr[ADDR_WIDTH-1:0];
                        wbuf_d = we;
                        cnt_d  = '0;
                    end else if (cnt_q == 4'(CLK_DELAY - 2)) begin
                        do_beat  = 1'b1;
                        cur_beat = '0;
                        beat_d   = ADDR_WIDTH'(1);
                        if (BURST_LEN == 1) begin
                            last_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BURST;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_BURST: begin
                    do_beat = 1'b1;
                    beat_d  = beat_q + ADDR_WIDTH'(1);
                    if (beat_q == LMASK) begin
                        last_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end

        mem_we = do_beat & wbuf_q;
        if (do_beat) begin
            ack_d = 1'b1;
            if (!wbuf_q) dout_d = mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            abuf_q  <= '0;
            wbuf_q  <= 1'b0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            abuf_q  <= abuf_d;
            wbuf_q  <= wbuf_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
`ifdef DATA_RAM_WSTRB_EN
            for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) mem[idx][b*8 +: 8] <= din[b*8 +: 8];
            end
`else
            mem[idx] <= din;
`endif
        end
    end

    assign dout  = dout_q;
    assign ack   = ack_q;
    assign last  = last_q;
    assign stall = cs & ~ack_q & (state_q != S_DONE);

endmodule
